layer_out_serializer: RTL
=========================

// Module: layer_out_serializer
// PURPOSE
//  Sits between the neuron array of layer N and the neurons of layer N+1.
//  Captures the NUM_NEURONS parallel activations when every neuron in the layer asserts outvalid.
//  Replays them as a serial stream: one activation per clk on out_data/out_valid.
//  That stream drives myinput/myinputValid, which is broadcast to all neurons of the next layer.
//  Index 0 is sent first, so beat k pairs with weight address k in the consuming neurons.
// PARAMETERS
//  NUM_NEURONS  10  neurons in the producing layer = beats per burst (>=2)
//  DATA_WIDTH   16  activation width (signed two's complement)
//  IDX_WIDTH    $clog2(NUM_NEURONS)  width of beat/class index
// PORTS
//  clk        in   1                        clock
//  rst        in   1                        synchronous, active-high reset
//  in_data    in   NUM_NEURONS*DATA_WIDTH   neuron outs; neuron i at [i*DATA_WIDTH +: DATA_WIDTH]
//  in_valid   in   NUM_NEURONS              per-neuron outvalid
//  out_data   out  DATA_WIDTH               serial activation
//  out_valid  out  1                        out_data valid (feeds next layer myinputValid)
//  busy       out  1                        burst in progress
//  err        out  2                        sticky: [0] overrun, [1] partial in_valid
//  class_idx  out  IDX_WIDTH                argmax index (LAYER_SER_ARGMAX_EN only)
//  class_vld  out  1                        one-cycle pulse, class_idx valid
// BEHAVIOUR
//  Reset values: out_data=0, out_valid=0, busy=0, err=0, class_idx=0, class_vld=0, state=IDLE.
//  Capture condition: in_valid == all ones.
//  - On capture, the whole in_data vector is latched into a shadow buffer.
//  FSM IDLE -> SEND on capture; SEND -> IDLE after beat NUM_NEURONS-1 unless a capture coincides.
//  Latency: capture at edge T gives beat k (out_valid=1, out_data=neuron k) registered at edge T+1+k.
//  - Last beat at T+NUM_NEURONS.
//  - out_valid is contiguous for exactly NUM_NEURONS cycles; there is no backpressure.
//  busy = 1 from T+1 to T+NUM_NEURONS inclusive.
//  Beat counter runs 0..NUM_NEURONS-1 and wraps to 0 at end of burst; it never exceeds NUM_NEURONS-1.
//  Capture in the same cycle the last beat is issued is legal.
//  - The new vector starts at the next edge with no bubble.
//  Capture while SEND, with beats still remaining:
//  - The new vector is dropped.
//  - err[0] is set.
//  - The current burst continues unchanged.
//  in_valid nonzero but not all ones:
//  - No capture.
//  - err[1] is set.
//  - The buffer is untouched.
//  err bits are sticky and are cleared only by rst.
//  rst mid-burst aborts the burst immediately: out_valid=0 at the next edge, and the buffer contents are don't-care.
//  Data is passed through bit-exact; there is no arithmetic on the datapath.
// CONFIGURATION
//  `LAYER_SER_ARGMAX_EN` defined:
//  - A running signed max over the beats is tracked as they issue.
//  - Strict > compare, so on ties the lowest index wins.
//  - class_idx is registered together with a class_vld pulse one cycle after the last beat (T+NUM_NEURONS+1).
//  - An aborted burst (rst) produces no pulse.
//  - Used on the final layer for classification.
//  Not defined:
//  - class_idx=0 and class_vld=0 constantly.
//  - No compare logic is synthesised.
// STRUCTURE
//  fnn_pkg holds:
//  - typedef enum logic {SER_IDLE, SER_SEND} ser_state_t;
//  - err bit index localparams ERR_OVERRUN=0, ERR_PARTIAL=1.
//  Sub-module argmax_tracker (inside the `ifdef):
//  - inputs: beat data, beat idx, first, last.
//  - outputs: class_idx, class_vld.
//  Shadow buffer and beat counter stay in the top module.
// TESTING
//  1 Reset: hold rst 3 cycles -> all outputs 0, state IDLE.
//  2 Single burst, NUM_NEURONS=10, neuron i = 16'h0100+i, all in_valid at T
//    -> out_data 0x0100..0x0109 at T+1..T+10, out_valid exactly 10 cycles, err=0.
//  3 Back-to-back: second capture at T+10 -> 20 contiguous out_valid cycles, second burst data correct, err=0.
//  4 Overrun: second capture at T+5 -> first burst completes intact, second vector never appears, err=2'b01.
//  5 Partial valid: in_valid=10'h1FF once -> no out_valid, err=2'b10; a following full capture is still serialized.
//  6 ARGMAX_EN: data {-3,7,2,7,-8,0,1,5,6,4} -> class_idx=1, class_vld pulse at T+11.
//    Then assert rst at T+4 of a new burst -> out_valid drops, and no class_vld pulse follows.

Source files
------------

// File: rtl/fnn_pkg.sv
// Shared types for the feed-forward network datapath.
// Serializer FSM states and sticky error bit positions.
package fnn_pkg;

    typedef enum logic {
        SER_IDLE,
        SER_SEND
    } ser_state_t;

    localparam int ERR_OVERRUN = 0;
    localparam int ERR_PARTIAL = 1;

endpackage

// File: rtl/layer_out_serializer_argmax.sv
// argmax_tracker: running signed max over a serial burst (LAYER_SER_ARGMAX_EN).
// Emits the winning index with a one-cycle pulse after the last beat.
`ifdef LAYER_SER_ARGMAX_EN
module argmax_tracker
    import fnn_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int IDX_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  beat_vld,
    input  logic [DATA_WIDTH-1:0] beat_data,
    input  logic [IDX_WIDTH-1:0]  beat_idx,
    input  logic                  first,
    input  logic                  last,
    output logic [IDX_WIDTH-1:0]  class_idx,
    output logic                  class_vld
);

    logic signed [DATA_WIDTH-1:0] max_q;
    logic [IDX_WIDTH-1:0]         idx_q;
    logic signed [DATA_WIDTH-1:0] data_s;
    logic                         take;

    assign data_s = beat_data;
    // strict compare keeps the lowest index on ties
    assign take   = first || (data_s > max_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            max_q     <= '0;
            idx_q     <= '0;
            class_idx <= '0;
            class_vld <= 1'b0;
        end else begin
            class_vld <= 1'b0;
            if (beat_vld) begin
                if (take) begin
                    max_q <= data_s;
                    idx_q <= beat_idx;
                end
                if (last) begin
                    class_idx <= take ? beat_idx : idx_q;
                    class_vld <= 1'b1;
                end
            end
        end
    end

endmodule
`endif

// File: rtl/layer_out_serializer.sv
// Captures a layer's parallel activations and replays them one per clk.
// Optional argmax classification output under LAYER_SER_ARGMAX_EN.
module layer_out_serializer
    import fnn_pkg::*;
#(
    parameter int NUM_NEURONS = 10,
    parameter int DATA_WIDTH  = 16,
    parameter int IDX_WIDTH   = $clog2(NUM_NEURONS)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_NEURONS*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_NEURONS-1:0]            in_valid,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic                              out_valid,
    output logic                              busy,
    output logic [1:0]                        err,
    output logic [IDX_WIDTH-1:0]              class_idx,
    output logic                              class_vld
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_NEURONS - 1);

    ser_state_t            state;
    logic [IDX_WIDTH-1:0]  cnt;
    logic [DATA_WIDTH-1:0] shadow [NUM_NEURONS];

    logic capture;
    logic partial;
    logic last;
    logic accept;
    logic overrun;

    assign capture = &in_valid;
    assign partial = (|in_valid) && !capture;
    assign last    = (state == SER_SEND) && (cnt == LAST_IDX);
    // a capture landing on the last beat chains the next burst with no bubble
    assign accept  = capture && ((state == SER_IDLE) || last);
    assign overrun = capture && (state == SER_SEND) && !last;

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                shadow[i] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SER_IDLE;
            cnt       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            err       <= '0;
        end else begin
            if (overrun) err[ERR_OVERRUN] <= 1'b1;
            if (partial) err[ERR_PARTIAL] <= 1'b1;
            unique case (state)
                SER_IDLE: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    cnt       <= '0;
                    if (capture) state <= SER_SEND;
                end
                SER_SEND: begin
                    out_valid <= 1'b1;
                    busy      <= 1'b1;
                    out_data  <= shadow[cnt];
                    if (last) begin
                        cnt <= '0;
                        if (!capture) state <= SER_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= SER_IDLE;
            endcase
        end
    end

`ifdef LAYER_SER_ARGMAX_EN
    logic [IDX_WIDTH-1:0] beat_idx;

    // index of the beat currently on out_data
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_idx <= '0;
        end else if (state == SER_SEND) begin
            beat_idx <= cnt;
        end
    end

    argmax_tracker #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_argmax (
        .clk       (clk),
        .rst       (rst),
        .beat_vld  (out_valid),
        .beat_data (out_data),
        .beat_idx  (beat_idx),
        .first     (beat_idx == '0),
        .last      (beat_idx == LAST_IDX),
        .class_idx (class_idx),
        .class_vld (class_vld)
    );
`else
    assign class_idx = '0;
    assign class_vld = 1'b0;
`endif

endmodule
